// File: rtl/grav_fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : grav_fp_pkg
//  Description : Shared float format (1 sign, 8 exponent, 18 mantissa,
//                bias 127) and the requester-index width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package grav_fp_pkg;

    localparam int c_fp_w   = 27;
    localparam int c_exp_w  = 8;
    localparam int c_man_w  = 18;
    localparam int c_bias   = 127;
    // All-ones exponent is reserved for infinity.
    localparam int c_exp_max = 2 * c_bias + 1;

    typedef struct packed {
        logic               sign;
        logic [c_exp_w-1:0] expo;
        logic [c_man_w-1:0] man;
    } fp_t;

    // Width of an index selecting one of n items (never zero).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_addr_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp_addr_sched_if
//  Description : Request/result bundle between the requesters and the
//                shared fp_addr scheduler.
//  Ports       : req_valid/req_ready/req_a/req_b/hold  - request side
//                res_valid/res_id/res_data               - result strobe
//                busy/inflight                           - occupancy status
//  Revision    : 1.0  initial release
// ============================================================================
interface fp_addr_sched_if
    import grav_fp_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = c_fp_w,
    parameter int LAT  = 3
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ*W-1:0]          req_a;
    logic [NREQ*W-1:0]          req_b;
    logic                       hold;
    logic                       res_valid;
    logic [idx_w(NREQ)-1:0]     res_id;
    logic [W-1:0]               res_data;
    logic                       busy;
    logic [$clog2(LAT+2)-1:0]   inflight;

    modport master (
        output req_valid, req_a, req_b, hold,
        input  req_ready, res_valid, res_id, res_data, busy, inflight
    );

    modport slave (
        input  req_valid, req_a, req_b, hold,
        output req_ready, res_valid, res_id, res_data, busy, inflight
    );
endinterface
`default_nettype wire

// File: rtl/fp_addr.sv
`default_nettype none
// ============================================================================
//  Module      : fp_addr
//  Description : Pipelined float adder, result LAT cycles after the operands.
//                Denormals are flushed to zero, rounding is truncation,
//                exponent overflow saturates to infinity.
//  Ports       : clk, rst (async, active-low), a, b (operands), sum (result)
//  Revision    : 1.0  initial release
// ============================================================================
module fp_addr
    import grav_fp_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic clk,
    input  logic rst,
    input  fp_t  a,
    input  fp_t  b,
    output fp_t  sum
);
    fp_t                w_big, w_small, w_res;
    logic [c_man_w:0]   w_mb, w_ms, w_ms_sh;
    logic [c_exp_w-1:0] w_ediff;
    logic [c_man_w+1:0] w_sum;
    logic [4:0]         w_lz;
    logic               w_hit;

    fp_t r_pipe [LAT];

    always_comb begin
        w_big   = a;
        w_small = b;
        w_res   = '0;
        w_lz    = '0;
        w_hit   = 1'b0;
        // Order by magnitude so the result sign is the larger operand's.
        if ({b.expo, b.man} > {a.expo, a.man}) begin
            w_big   = b;
            w_small = a;
        end
        w_mb    = (w_big.expo   != '0) ? {1'b1, w_big.man}   : '0;
        w_ms    = (w_small.expo != '0) ? {1'b1, w_small.man} : '0;
        w_ediff = w_big.expo - w_small.expo;
        w_ms_sh = (w_ediff > 8'(c_man_w)) ? '0 : (w_ms >> w_ediff);
        if (w_big.sign == w_small.sign)
            w_sum = {1'b0, w_mb} + {1'b0, w_ms_sh};
        else
            w_sum = {1'b0, w_mb} - {1'b0, w_ms_sh};
        for (int i = c_man_w; i >= 0; i--) begin
            if (!w_hit && w_sum[i]) begin
                w_hit = 1'b1;
                w_lz  = 5'(c_man_w - i);
            end
        end

        if (w_big.expo == '0) begin
            w_res = '0;
        end else if (w_sum[c_man_w+1]) begin
            if (w_big.expo >= c_exp_w'(c_exp_max - 1))
                w_res = {w_big.sign, {c_exp_w{1'b1}}, {c_man_w{1'b0}}};
            else
                w_res = {w_big.sign, w_big.expo + c_exp_w'(1), w_sum[c_man_w:1]};
        end else if (!w_hit || (w_big.expo <= {3'b000, w_lz})) begin
            // Exact cancellation or underflow below the normal range.
            w_res = '0;
        end else begin
            w_res = {w_big.sign, w_big.expo - {3'b000, w_lz},
                     c_man_w'(w_sum[c_man_w:0] << w_lz)};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= w_res;
            for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign sum = r_pipe[LAT-1];

endmodule
`default_nettype wire

// File: rtl/fp_addr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fp_addr_sched
//  Description : Round-robin scheduler sharing one fp_addr among NREQ
//                requesters; a tag pipeline returns the owner id with
//                each result, in issue order.
//  Ports       : clk, rst (async, active-low), bus (fp_addr_sched_if.slave)
//  Revision    : 1.0  initial release
// ============================================================================
module fp_addr_sched
    import grav_fp_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = c_fp_w,
    parameter int LAT  = 3
) (
    input  logic            clk,
    input  logic            rst,
    fp_addr_sched_if.slave  bus
);
    localparam int c_idw   = idx_w(NREQ);
    localparam int c_cnt_w = $clog2(LAT+2);

    logic [c_idw-1:0]   r_ptr;
    logic [c_idw-1:0]   w_idx, w_gnt_id;
    logic               w_found, w_xfer;
    logic [NREQ-1:0]    w_ready;
    logic [W-1:0]       w_a, w_b;
    logic [W-1:0]       r_op_a, r_op_b;
    fp_t                w_sum;
    // Stage 0 is captured alongside the operand register; stages 1..LAT
    // track the adder pipeline so stage LAT lines up with its output.
    logic [LAT:0]       r_tag_v;
    logic [c_idw-1:0]   r_tag_id [LAT+1];
    logic [c_cnt_w-1:0] r_inflight;

    // First asserted requester at or after the pointer, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = c_idw'((int'(r_ptr) + k) % NREQ);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx;
            end
        end
    end

    assign w_ready = (w_found && !bus.hold && rst) ? (NREQ'(1) << w_gnt_id) : '0;
    assign w_xfer  = |(bus.req_valid & w_ready);

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_id == c_idw'(i)) begin
                w_a = bus.req_a[i*W +: W];
                w_b = bus.req_b[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr  <= '0;
            r_op_a <= '0;
            r_op_b <= '0;
        end else if (w_xfer) begin
            r_ptr  <= (int'(w_gnt_id) == NREQ-1) ? '0 : w_gnt_id + c_idw'(1);
            r_op_a <= w_a;
            r_op_b <= w_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_v <= '0;
            for (int i = 0; i <= LAT; i++) r_tag_id[i] <= '0;
        end else begin
            r_tag_v     <= {r_tag_v[LAT-1:0], w_xfer};
            // Bubbles carry id 0 so res_id reads 0 whenever res_valid is low.
            r_tag_id[0] <= w_xfer ? w_gnt_id : '0;
            for (int i = 1; i <= LAT; i++) r_tag_id[i] <= r_tag_id[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_xfer, r_tag_v[LAT]})
                2'b10:   r_inflight <= r_inflight + c_cnt_w'(1);
                2'b01:   r_inflight <= r_inflight - c_cnt_w'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    fp_addr #(.LAT(LAT)) u_fp_addr (
        .clk (clk),
        .rst (rst),
        .a   (r_op_a),
        .b   (r_op_b),
        .sum (w_sum)
    );

    assign bus.req_ready = w_ready;
    assign bus.res_valid = r_tag_v[LAT];
    assign bus.res_id    = r_tag_id[LAT];
    assign bus.res_data  = w_sum;
    assign bus.busy      = (r_inflight != '0);
    assign bus.inflight  = r_inflight;

endmodule
`default_nettype wire

// File: tb/tb_fp_addr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_addr_sched
//  Description : Directed self-checking bench for fp_addr_sched.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp_addr_sched;
    localparam int NREQ = 4;
    localparam int W    = 27;
    localparam int LAT  = 3;

    localparam logic [W-1:0] c_f2p5 = 27'b0_10000000_010000000000000000;
    localparam logic [W-1:0] c_f5p0 = 27'b0_10000001_010000000000000000;
    localparam logic [W-1:0] c_f6p5 = 27'b0_10000001_101000000000000000;
    localparam logic [W-1:0] c_f9p0 = 27'b0_10000010_001000000000000000;
    // inflight after each edge when four one-shot requests issue back to back
    localparam int c_infl [8] = '{1, 2, 3, 4, 3, 2, 1, 0};
    // grant order from pointer 3 with all requesters valid
    localparam logic [3:0] c_ord3 [3] = '{4'b1000, 4'b0001, 4'b0010};

    logic tst_clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    fp_addr_sched_if #(.NREQ(NREQ), .W(W), .LAT(LAT)) bus ();

    fp_addr_sched #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
        .clk (tst_clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 tst_clk = ~tst_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge tst_clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        @(posedge tst_clk);
        #2 rst = 1'b1;
    endtask

    // Called right after a lone transfer edge: result appears LAT edges later.
    task automatic expect_result(input int id, input logic [W-1:0] data);
        for (int k = 1; k <= LAT; k++) begin
            step();
            check("res_valid_latency", 64'(bus.res_valid), 64'(k == LAT));
        end
        check("res_id", 64'(bus.res_id), 64'(id));
        check("res_data", 64'(bus.res_data), 64'(data));
        step();
        check("res_valid_single", 64'(bus.res_valid), 64'd0);
        check("busy_drained", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        rst           = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_a     = {NREQ{c_f2p5}};
        bus.req_b     = {NREQ{c_f2p5}};
        bus.hold      = 1'b0;

        // Reset state
        repeat (2) @(posedge tst_clk);
        #2;
        check("rst_ready", 64'(bus.req_ready), 64'd0);
        check("rst_res_valid", 64'(bus.res_valid), 64'd0);
        check("rst_res_id", 64'(bus.res_id), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_inflight", 64'(bus.inflight), 64'd0);
        bus.req_valid = '0;
        #1 rst = 1'b1;

        // Single operation 2.5 + 2.5 from requester 0
        bus.req_valid = 4'b0001;
        #1;
        check("t1_ready", 64'(bus.req_ready), 64'd1);
        step();
        bus.req_valid = '0;
        check("t1_inflight", 64'(bus.inflight), 64'd1);
        check("t1_busy", 64'(bus.busy), 64'd1);
        expect_result(0, c_f5p0);

        // All four together: grants 0..3, results 0..3 back to back
        do_reset();
        bus.req_valid = 4'b1111;
        for (int e = 0; e < 8; e++) begin
            #1;
            check("t2_ready", 64'(bus.req_ready), (e < 4) ? (64'd1 << e) : 64'd0);
            step();
            if (e < 4) bus.req_valid = bus.req_valid & ~(4'b0001 << e);
            check("t2_inflight", 64'(bus.inflight), 64'(c_infl[e]));
            check("t2_res_valid", 64'(bus.res_valid), 64'(e >= 3 && e <= 6));
            if (e >= 3 && e <= 6) begin
                check("t2_res_id", 64'(bus.res_id), 64'(e - 3));
                check("t2_res_data", 64'(bus.res_data), 64'(c_f5p0));
            end
        end

        // Requesters 1 and 3 held valid: strict alternation
        bus.req_valid = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("t3_alternate", 64'(bus.req_ready), (i % 2 == 0) ? 64'h2 : 64'h8);
            step();
        end
        bus.req_valid = '0;
        repeat (LAT + 2) step();
        check("t3_drained", 64'(bus.inflight), 64'd0);

        // Hold with requester 2 waiting while requester 0's op drains
        bus.req_valid = 4'b0001;
        #1;
        check("t4_pre_ready", 64'(bus.req_ready), 64'h1);
        step();
        bus.req_valid = 4'b0100;
        bus.hold      = 1'b1;
        for (int h = 1; h <= 5; h++) begin
            #1;
            check("t4_hold_ready", 64'(bus.req_ready), 64'd0);
            step();
            check("t4_hold_res_valid", 64'(bus.res_valid), 64'(h == 3));
            check("t4_hold_inflight", 64'(bus.inflight), (h <= 3) ? 64'd1 : 64'd0);
        end
        bus.hold = 1'b0;
        #1;
        check("t4_resume_ready", 64'(bus.req_ready), 64'h4);
        step();
        bus.req_valid = '0;
        check("t4_resume_inflight", 64'(bus.inflight), 64'd1);
        expect_result(2, c_f5p0);

        // Reset with three operations in flight (pointer starts at 3)
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5_ready", 64'(bus.req_ready), 64'(c_ord3[i]));
            step();
        end
        check("t5_inflight3", 64'(bus.inflight), 64'd3);
        #2 rst = 1'b0;
        #1;
        check("t5_async_inflight", 64'(bus.inflight), 64'd0);
        check("t5_async_busy", 64'(bus.busy), 64'd0);
        check("t5_async_res_valid", 64'(bus.res_valid), 64'd0);
        check("t5_async_res_id", 64'(bus.res_id), 64'd0);
        check("t5_async_ready", 64'(bus.req_ready), 64'd0);
        bus.req_valid = '0;
        @(posedge tst_clk);
        #2 rst = 1'b1;
        for (int k = 0; k < LAT + 2; k++) begin
            step();
            check("t5_no_stale_result", 64'(bus.res_valid), 64'd0);
        end
        bus.req_valid = 4'b1111;
        #1;
        check("t5_ptr_zero", 64'(bus.req_ready), 64'h1);
        step();
        bus.req_valid = '0;
        expect_result(0, c_f5p0);

        // 6.5+2.5 from requester 1, then 2.5+2.5 from requester 2
        bus.req_a     = {c_f2p5, c_f2p5, c_f6p5, c_f2p5};
        bus.req_valid = 4'b0010;
        #1;
        check("t6_ready1", 64'(bus.req_ready), 64'h2);
        step();
        bus.req_valid = 4'b0100;
        #1;
        check("t6_ready2", 64'(bus.req_ready), 64'h4);
        step();
        bus.req_valid = '0;
        step();
        check("t6_gap", 64'(bus.res_valid), 64'd0);
        step();
        check("t6_v1", 64'(bus.res_valid), 64'd1);
        check("t6_id1", 64'(bus.res_id), 64'd1);
        check("t6_sum_9p0", 64'(bus.res_data), 64'(c_f9p0));
        step();
        check("t6_v2", 64'(bus.res_valid), 64'd1);
        check("t6_id2", 64'(bus.res_id), 64'd2);
        check("t6_sum_5p0", 64'(bus.res_data), 64'(c_f5p0));
        step();
        check("t6_end_valid", 64'(bus.res_valid), 64'd0);
        check("t6_end_busy", 64'(bus.busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
